// File: rtl/pmc_counter_bank.sv
// Parametrised performance-monitor counter bank: NUM_CNT event counters with run/hold FSM,
// snapshot shadow bank, sticky overflow and a registered read port. Option: PMC_SATURATE_EN.
module pmc_counter_bank #(
    parameter int NUM_CNT = 4,
    parameter int CNT_W   = 32,
    parameter int NUM_EVT = 8,
    parameter int IDX_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1,
    parameter int SEL_W   = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_EVT-1:0] evt_in,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [SEL_W-1:0]   cfg_sel,
    input  logic               cfg_edge,
    input  logic               snap,
    input  logic [IDX_W-1:0]   rd_idx,
    input  logic               rd_shadow,
    output logic [CNT_W-1:0]   rd_data,
    output logic [NUM_CNT-1:0] ovf,
    output logic               running
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_running;

    logic [CNT_W-1:0]     r_cnt    [NUM_CNT];
    logic [CNT_W-1:0]     r_shadow [NUM_CNT];
    logic [SEL_W-1:0]     r_sel    [NUM_CNT];
    logic [NUM_CNT-1:0]   r_edge;
    logic [NUM_CNT-1:0]   r_ovf;
    logic [NUM_EVT-1:0]   r_evt_prev;
    logic [CNT_W-1:0]     r_rd_data;

    logic [NUM_CNT-1:0]   w_evt_cur;
    logic [NUM_CNT-1:0]   w_evt_old;
    logic [NUM_CNT-1:0]   w_inc;
    logic [NUM_CNT-1:0]   w_at_max;
    logic                 w_cfg_ok;
    logic [CNT_W-1:0]     w_rd_val;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == ST_RUN);
        end
    end

    // stop outranks start in every state, so start+stop never enters RUN
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (!stop && start) w_state_nxt = ST_RUN;
                ST_RUN:  if (stop)           w_state_nxt = ST_HOLD;
                ST_HOLD: if (!stop && start) w_state_nxt = ST_RUN;
                default:                     w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ---------------- event selection ----------------
    always_comb begin
        w_evt_cur = '0;
        w_evt_old = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            for (int unsigned j = 0; j < NUM_EVT; j++) begin
                if (32'(r_sel[i]) == j) begin
                    w_evt_cur[i] = evt_in[j];
                    w_evt_old[i] = r_evt_prev[j];
                end
            end
        end
    end

    always_comb begin
        w_inc    = '0;
        w_at_max = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            w_at_max[i] = &r_cnt[i];
            if (r_state == ST_RUN) begin
                w_inc[i] = r_edge[i] ? (w_evt_cur[i] & ~w_evt_old[i]) : w_evt_cur[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_evt_prev <= '0;
        end else begin
            r_evt_prev <= evt_in;
        end
    end

    // ---------------- configuration ----------------
    assign w_cfg_ok = cfg_we && (r_state != ST_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                r_sel[i]  <= SEL_W'(i % NUM_EVT);
                r_edge[i] <= 1'b0;
            end
        end else if (w_cfg_ok) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                if (32'(cfg_idx) == i) begin
                    r_sel[i]  <= cfg_sel;
                    r_edge[i] <= cfg_edge;
                end
            end
        end
    end

    // ---------------- counters, shadows, overflow ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= '0;
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                r_cnt[i]    <= '0;
                r_shadow[i] <= '0;
            end
        end else if (clear) begin
            r_ovf <= '0;
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                r_cnt[i]    <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                if (snap) begin
                    r_shadow[i] <= r_cnt[i];
                end
                if (w_inc[i]) begin
                    if (w_at_max[i]) begin
                        r_ovf[i] <= 1'b1;
`ifdef PMC_SATURATE_EN
                        r_cnt[i] <= r_cnt[i];
`else
                        r_cnt[i] <= '0;
`endif
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // ---------------- read port ----------------
    always_comb begin
        w_rd_val = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (32'(rd_idx) == i) begin
                w_rd_val = rd_shadow ? r_shadow[i] : r_cnt[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_val;
        end
    end

    assign rd_data = r_rd_data;
    assign ovf     = r_ovf;
    assign running = r_running;

endmodule

// File: tb/tb_pmc_counter_bank.sv
// Self-checking bench for pmc_counter_bank (NUM_CNT=4, CNT_W=8, NUM_EVT=8): cycle model plus
// directed literal checks. Expectations follow PMC_SATURATE_EN when it is defined.
module tb_pmc_counter_bank;

    logic       clk;
    logic       reset;
    logic [7:0] evt_in;
    logic       start, stop, clear;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [2:0] cfg_sel;
    logic       cfg_edge;
    logic       snap;
    logic [1:0] rd_idx;
    logic       rd_shadow;
    logic [7:0] rd_data;
    logic [3:0] ovf;
    logic       running;

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 0;

`ifdef PMC_SATURATE_EN
    localparam int T3_EXP = 255;
`else
    localparam int T3_EXP = 1;
`endif

    pmc_counter_bank #(.NUM_CNT(4), .CNT_W(8), .NUM_EVT(8)) dut (
        .clk(clk), .reset(reset), .evt_in(evt_in),
        .start(start), .stop(stop), .clear(clear),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_edge(cfg_edge),
        .snap(snap), .rd_idx(rd_idx), .rd_shadow(rd_shadow),
        .rd_data(rd_data), .ovf(ovf), .running(running)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // state: 0 idle, 1 run, 2 hold
    int       m_state;
    int       m_cnt [4];
    int       m_sh  [4];
    int       m_sel [4];
    bit       m_edge[4];
    bit       m_ovf [4];
    bit [7:0] m_prev;
    int       m_rd;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_state = 0;
                m_prev  = '0;
                m_rd    = 0;
                for (int i = 0; i < 4; i++) begin
                    m_cnt[i] = 0; m_sh[i] = 0; m_ovf[i] = 0;
                    m_sel[i] = i % 8; m_edge[i] = 0;
                end
            end else begin
                int  nrd;
                bit  cur, hit;
                nrd = rd_shadow ? m_sh[rd_idx] : m_cnt[rd_idx];
                if (clear) begin
                    for (int i = 0; i < 4; i++) begin
                        m_cnt[i] = 0; m_sh[i] = 0; m_ovf[i] = 0;
                    end
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (snap) m_sh[i] = m_cnt[i];
                        cur = evt_in[m_sel[i]];
                        hit = m_edge[i] ? (cur && !m_prev[m_sel[i]]) : cur;
                        if (m_state == 1 && hit) begin
                            if (m_cnt[i] == 255) begin
                                m_ovf[i] = 1;
`ifdef PMC_SATURATE_EN
                                m_cnt[i] = 255;
`else
                                m_cnt[i] = 0;
`endif
                            end else begin
                                m_cnt[i] = m_cnt[i] + 1;
                            end
                        end
                    end
                end
                if (cfg_we && m_state != 1) begin
                    m_sel[cfg_idx]  = cfg_sel;
                    m_edge[cfg_idx] = cfg_edge;
                end
                if (clear)                        m_state = 0;
                else if (stop && m_state == 1)    m_state = 2;
                else if (stop)                    m_state = m_state;
                else if (start)                   m_state = 1;
                m_prev = evt_in;
                m_rd   = nrd;
            end
        end
    end

    // compare process: outputs checked against the model on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                logic [3:0] exp_ovf;
                for (int i = 0; i < 4; i++) exp_ovf[i] = m_ovf[i];
                check("cyc_running", 64'(running), 64'(m_state == 1));
                check("cyc_ovf",     64'(ovf),     64'(exp_ovf));
                check("cyc_rd_data", 64'(rd_data), 64'(m_rd));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic expect_rd(input int idx, input bit sh, input int lit, input string name);
        rd_idx    = 2'(idx);
        rd_shadow = sh;
        tick();
        check(name, 64'(rd_data), 64'(lit));
    endtask

    task automatic read_all();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 4; i++) begin
                rd_idx = 2'(i); rd_shadow = s[0];
                tick();
            end
        end
    endtask

    task automatic pulse_start(); start = 1; tick(); start = 0; endtask
    task automatic pulse_stop();  stop  = 1; tick(); stop  = 0; endtask
    task automatic pulse_clear(); clear = 1; tick(); clear = 0; endtask

    initial begin
        reset = 1; evt_in = '0; start = 0; stop = 0; clear = 0;
        cfg_we = 0; cfg_idx = '0; cfg_sel = '0; cfg_edge = 0;
        snap = 0; rd_idx = '0; rd_shadow = 0;
        ticks(2);
        reset = 0;
        chk_en = 1;

        // reset state
        check("rst_running", 64'(running), 64'd0);
        check("rst_ovf",     64'(ovf),     64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);

        // T1 level count
        pulse_start();
        check("t1_running_on", 64'(running), 64'd1);
        evt_in = 8'h01;
        ticks(10);
        evt_in = 8'h00;
        pulse_stop();
        check("t1_running_off", 64'(running), 64'd0);
        expect_rd(0, 0, 10, "t1_live0");
        expect_rd(1, 0, 0,  "t1_live1");
        expect_rd(3, 0, 0,  "t1_live3");

        // T2 edge mode
        pulse_clear();
        cfg_we = 1; cfg_idx = 2'd1; cfg_sel = 3'd2; cfg_edge = 1;
        tick();
        cfg_we = 0;
        pulse_start();
        foreach (evt_in[k]) begin end
        begin
            bit [6:0] pat;
            pat = 7'b1011101;
            for (int k = 6; k >= 0; k--) begin
                evt_in = pat[k] ? 8'h04 : 8'h00;
                tick();
            end
        end
        evt_in = 8'h04;
        tick();
        pulse_stop();
        tick();
        pulse_start();
        tick();
        evt_in = 8'h00;
        pulse_stop();
        expect_rd(1, 0, 3, "t2_edge_cnt1");
        expect_rd(2, 0, 8, "t2_level_cnt2");
        read_all();

        // T3 overflow
        pulse_clear();
        pulse_start();
        evt_in = 8'h01;
        ticks(257);
        evt_in = 8'h00;
        pulse_stop();
        check("t3_ovf", 64'(ovf), 64'd1);
        expect_rd(0, 0, T3_EXP, "t3_live0");
        pulse_clear();
        check("t3_clr_ovf",     64'(ovf),     64'd0);
        check("t3_clr_running", 64'(running), 64'd0);
        expect_rd(0, 0, 0, "t3_clr_live0");

        // T4 snapshot
        pulse_start();
        evt_in = 8'h01;
        ticks(41);
        snap = 1;
        tick();
        snap = 0;
        expect_rd(0, 1, 41, "t4_shadow0");
        expect_rd(0, 0, 43, "t4_live0");

        // T5 control priority and config lockout in RUN
        start = 1; stop = 1;
        tick();
        start = 0; stop = 0;
        check("t5_startstop_hold", 64'(running), 64'd0);
        pulse_start();
        cfg_we = 1; cfg_idx = 2'd0; cfg_sel = 3'd5; cfg_edge = 1;
        tick();
        cfg_we = 0;
        ticks(3);
        evt_in = 8'h00;
        pulse_stop();
        expect_rd(0, 0, 49, "t5_cfg_ignored");
        expect_rd(0, 1, 41, "t5_shadow_kept");
        clear = 1; snap = 1;
        tick();
        clear = 0; snap = 0;
        expect_rd(0, 1, 0, "t5_clear_snap");
        read_all();

        // T6 asynchronous reset mid-RUN
        rd_idx = 2'd0; rd_shadow = 0;
        pulse_start();
        evt_in = 8'h01;
        ticks(100);
        check("t6_pre_rd", 64'(rd_data), 64'd99);
        #1 reset = 1;
        #1;
        check("t6_async_running", 64'(running), 64'd0);
        check("t6_async_rd_data", 64'(rd_data), 64'd0);
        check("t6_async_ovf",     64'(ovf),     64'd0);
        evt_in = 8'h00;
        tick();
        reset = 0;
        pulse_start();
        evt_in = 8'h02;
        ticks(3);
        evt_in = 8'h00;
        pulse_stop();
        expect_rd(1, 0, 3, "t6_cfg_default1");
        expect_rd(2, 0, 0, "t6_cfg_default2");
        expect_rd(0, 0, 0, "t6_live0");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pmc_counter_bank.md
Name: pmc_counter_bank

Overview:
- Parametrised performance-monitor counter bank; successor to the fixed three-counter PMC block.
- Provides NUM_CNT independent counters. Each counter is runtime-mapped to one of NUM_EVT pipeline event lines (stall, arith, mem access, ...).
- Each counter counts per cycle (level mode) or per rising edge (edge mode).
- Adds a global run/hold control FSM, an atomic snapshot shadow bank, sticky overflow flags and a registered read port for the debug/host readout logic.

Parameters:
- NUM_CNT, 4, number of counters (1..16).
- CNT_W, 32, counter width in bits (8..64).
- NUM_EVT, 8, number of event input lines (1..32).
- IDX_W, $clog2(NUM_CNT) (min 1), counter index width (derived).
- SEL_W, $clog2(NUM_EVT) (min 1), event select width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- evt_in  in  NUM_EVT  event lines, synchronous to clk, sampled every cycle
- start  in  1  enter/resume counting
- stop  in  1  hold counting
- clear  in  1  zero all counters, shadows and flags, and return to IDLE
- cfg_we  in  1  configuration write strobe
- cfg_idx  in  IDX_W  counter being configured
- cfg_sel  in  SEL_W  event index for that counter
- cfg_edge  in  1  1 = edge mode, 0 = level mode
- snap  in  1  copy all live counters to the shadow bank
- rd_idx  in  IDX_W  read index
- rd_shadow  in  1  1 = read shadow bank, 0 = read live counter
- rd_data  out  CNT_W  registered read data
- ovf  out  NUM_CNT  sticky per-counter overflow flags
- running  out  1  high while FSM is in RUN

Behaviour:
- Reset is asynchronous, active-high, on clock clk.
- Reset values:
  - All live counters, shadows, rd_data, ovf and evt_prev = 0.
  - FSM = IDLE; running = 0.
  - Counter i config: sel = i mod NUM_EVT, edge = 0.
- FSM states: IDLE, RUN, HOLD.
  - IDLE --start--> RUN
  - RUN --stop--> HOLD
  - HOLD --start--> RUN (resume; values kept)
  - any state --clear--> IDLE
  - Priority: clear > stop > start. start and stop together in RUN -> HOLD.
- running = (state == RUN), registered.
- Counting happens only while state == RUN, in the cycle after the transition into RUN.
  - Level mode: +1 each cycle evt_in[sel] = 1.
  - Edge mode: +1 when evt_in[sel] = 1 and evt_prev[sel] = 0.
- evt_prev <= evt_in every cycle in all states, so resuming never creates a false edge from stale history.
- Wrap: a counter at all-ones that increments becomes 0 and sets ovf[i]. ovf is sticky and cleared only by clear or reset.
- Config writes:
  - cfg_we is accepted in IDLE and HOLD only; ignored in RUN.
  - A write updates sel/edge for cfg_idx and leaves the count value unchanged.
  - cfg_idx >= NUM_CNT: write ignored.
- Snapshot:
  - snap copies all NUM_CNT live values into the shadows in the same edge, in any state.
  - Captured value is the pre-increment value of that cycle.
  - snap together with clear: clear wins; shadows are zeroed.
- clear zeros live counters, shadows and ovf. It does not alter config or evt_prev.
- Read port:
  - 1-cycle latency: rd_data <= rd_shadow ? shadow[rd_idx] : live[rd_idx], using the live value before this cycle's increment.
  - rd_idx >= NUM_CNT returns 0.

Optional Feature:
- Macro: PMC_SATURATE_EN.
- Defined: counters saturate at all-ones and hold there. ovf[i] is set on the first increment attempted while the counter is at all-ones.
- Not defined: wrap-around behaviour as specified above.

Test Plan:
- T1 reset/level count (NUM_CNT=4, CNT_W=8): reset, start, drive evt_in[0] high for 10 cycles, stop -> live[0] = 10, running = 0, rd_idx=0 returns 10 one cycle later; live[1..3] = 0.
- T2 edge mode: in IDLE set cnt1 sel=2, edge=1. Start, toggle evt_in[2] 1,0,1,1,1,0,1 -> live[1] = 3. Hold evt_in[2] high across stop/start -> no extra count.
- T3 overflow: CNT_W=8, level count 257 cycles -> live[0] = 1, ovf[0] = 1. With PMC_SATURATE_EN -> live[0] = 255, ovf[0] = 1. clear -> 0, ovf = 0, FSM IDLE.
- T4 snapshot: counter at 41 with event high, assert snap -> shadow[0] = 41, live = 42. rd_shadow=1 returns 41 while live continues counting.
- T5 control priority: in RUN assert start+stop -> HOLD. cfg_we in RUN ignored (sel unchanged). clear+snap together -> shadows 0.
- T6 async reset mid-RUN at count 100 -> all outputs 0 immediately, without waiting for a clk edge; config back to defaults.
